// File: rtl/ps2_pkg.sv
// Shared types, default timing and parity helper for the PS/2 host transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, DATA, PARITY, ACK, WAIT_IDLE, ABORT
    } ps2_state_t;

    // Defaults assume a 50 MHz system clock.
    localparam int INHIBIT_CYCLES_DEF = 6000;
    localparam int START_TIMEOUT_DEF  = 750000;
    localparam int FRAME_TIMEOUT_DEF  = 100000;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the requesting logic and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic       send;
    logic [7:0] tx_data;
    logic       ready;
    logic       done;
    logic       error;

    modport master (output send, output tx_data, input ready, input done, input error);
    modport slave  (input send, input tx_data, output ready, output done, output error);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for a raw PS/2 pin plus a falling-edge strobe.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic sync,
    output logic fall
);
    logic [1:0] ff_q, ff_d;
    logic       prev_q, prev_d;

    always_comb begin
        ff_d   = {ff_q[0], d_in};
        prev_d = ff_q[1];
    end

    // Idle PS/2 lines float high, so preset to 1 to avoid a false edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q   <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            ff_q   <= ff_d;
            prev_q <= prev_d;
        end
    end

    assign sync = ff_q[1];
    assign fall = prev_q & ~ff_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop and device ACK, with start and frame timeouts.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int START_TIMEOUT  = START_TIMEOUT_DEF,
    parameter int FRAME_TIMEOUT  = FRAME_TIMEOUT_DEF
) (
    input  logic           CLOCK_50,
    input  logic           reset_n,
    ps2_host_tx_if.slave   host,
    output logic           rx_inhibit,
    input  logic           ps2_clk_in,
    input  logic           ps2_dat_in,
    output logic           ps2_clk_oe,
    output logic           ps2_dat_oe
);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    // Timeouts fire two short so the error pulse (one ABORT cycle later, then
    // registered) lands exactly TIMEOUT cycles after the reference event.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 2);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 2);

    ps2_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       tx_q, tx_d;
    logic             ok_q, ok_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic clk_s, clk_fall, dat_s, unused_dat_fall;

    ps2_line_sync u_clk_sync (.clk(CLOCK_50), .rst_n(reset_n), .d_in(ps2_clk_in), .sync(clk_s), .fall(clk_fall));
    ps2_line_sync u_dat_sync (.clk(CLOCK_50), .rst_n(reset_n), .d_in(ps2_dat_in), .sync(dat_s), .fall(unused_dat_fall));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        tx_d     = tx_q;
        ok_d     = ok_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            IDLE: if (host.send) begin
                tx_d     = host.tx_data;
                cnt_d    = '0;
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b0;
                state_d  = INHIBIT;
            end
            INHIBIT: if (cnt_q == INH_LAST) begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b1;
                cnt_d    = '0;
                state_d  = REQ;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            REQ: if (clk_fall) begin
                dat_oe_d = ~tx_q[0];
                idx_d    = 4'd1;
                cnt_d    = '0;
                state_d  = DATA;
            end else if (cnt_q == START_LAST) begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ABORT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DATA, PARITY, ACK: begin
                cnt_d = cnt_q + 1'b1;
                if (clk_fall) begin
                    case (state_q)
                        DATA: if (idx_q == 4'd8) begin
                            dat_oe_d = ~odd_parity(tx_q);
                            state_d  = PARITY;
                        end else begin
                            dat_oe_d = ~tx_q[idx_q[2:0]];
                            idx_d    = idx_q + 4'd1;
                        end
                        PARITY: begin
                            dat_oe_d = 1'b0;
                            state_d  = ACK;
                        end
                        default: begin
                            ok_d    = ~dat_s;
                            state_d = WAIT_IDLE;
                        end
                    endcase
                end
                // A timeout outranks a coincident edge.
                if (cnt_q == FRAME_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = ABORT;
                end
            end
            WAIT_IDLE: if (clk_s && dat_s) begin
                done_d  = ok_q;
                error_d = ~ok_q;
                state_d = IDLE;
            end
            ABORT: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                error_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            tx_q     <= '0;
            ok_q     <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            ok_q     <= ok_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign host.ready  = (state_q == IDLE);
    assign host.done   = done_q;
    assign host.error  = error_q;
    assign rx_inhibit  = (state_q != IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_dat_oe  = dat_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural open-drain PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH = 60;
    localparam int ST  = 2000;
    localparam int FT  = 1500;
    localparam int H   = 40;

    logic clk = 1'b0;
    logic reset_n;
    logic rx_inhibit, clk_oe, dat_oe;
    logic dev_clk, dev_dat;
    wire  clk_line = clk_oe ? 1'b0 : dev_clk;
    wire  dat_line = dat_oe ? 1'b0 : dev_dat;

    int compared = 0;
    int mismatched = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_hi_cnt = 0, xfer_cnt = 0;
    logic clk_oe_prev = 1'b0;

    ps2_host_tx_if hif ();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(ST), .FRAME_TIMEOUT(FT)) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .host(hif.slave), .rx_inhibit(rx_inhibit),
        .ps2_clk_in(clk_line), .ps2_dat_in(dat_line), .ps2_clk_oe(clk_oe), .ps2_dat_oe(dat_oe)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (hif.done) done_cnt++;
        if (hif.error) err_cnt++;
        if (hif.done && hif.error) both_cnt++;
        if (rx_inhibit) inh_hi_cnt++;
        if (clk_oe && !clk_oe_prev) xfer_cnt++;
        clk_oe_prev = clk_oe;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        hif.send = 1'b1;
        hif.tx_data = b;
        @(negedge clk);
        hif.send = 1'b0;
    endtask

    // Device side of one frame; bits = {stop, parity, data[7:0], start}.
    task automatic dev_frame(input bit ack, input bit busy, input bit rst_mid,
                             output logic [10:0] bits, output int inh);
        int t = 0;
        bits = 'x;
        inh = 0;
        while (!clk_oe && t < 20) begin @(negedge clk); t++; end
        check("req_inhibit_seen", {31'd0, clk_oe}, 32'd1);
        if (!clk_oe) return;
        while (clk_oe && inh < INH + 100) begin inh++; @(negedge clk); end
        bits[0] = dat_line;
        repeat (H) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            if (rst_mid && k == 5) begin
                repeat (10) @(negedge clk);
                reset_n = 1'b0;
                #1;
                return;
            end
            if (busy && k == 4) begin
                send_byte(8'h00);
                repeat (H - 2) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            dev_clk = 1'b1;
            bits[k] = dat_line;
            repeat (H) @(negedge clk);
        end
        repeat (H / 2) @(negedge clk);
        if (ack) dev_dat = 1'b0;
        repeat (H / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H / 2) @(negedge clk);
        dev_dat = 1'b1;
    endtask

    task automatic wait_result(input int d0, input int e0);
        int t = 0;
        while (done_cnt == d0 && err_cnt == e0 && t < 500) begin @(negedge clk); t++; end
        check("result_in_time", {31'd0, (t < 500)}, 32'd1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [10:0] bits;
        int inh, d0, e0, x0, r0, n;

        reset_n = 1'b0;
        hif.send = 1'b0;
        hif.tx_data = 8'h00;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_outputs", {26'd0, hif.ready, hif.done, hif.error, rx_inhibit, clk_oe, dat_oe}, 32'b100000);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 0xED with ACK
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hED);
        dev_frame(1'b1, 1'b0, 1'b0, bits, inh);
        check("ed_inhibit_len", inh, INH);
        check("ed_bits", {21'd0, bits}, {21'd0, 1'b1, 1'b1, 8'hED, 1'b0});
        wait_result(d0, e0);
        check("ed_done", done_cnt - d0, 1);
        check("ed_no_error", err_cnt - e0, 0);
        check("ed_ready", {31'd0, hif.ready}, 32'd1);

        // 2: 0xFF, device withholds ACK
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hFF);
        dev_frame(1'b0, 1'b0, 1'b0, bits, inh);
        check("ff_bits", {21'd0, bits}, {21'd0, 1'b1, 1'b1, 8'hFF, 1'b0});
        wait_result(d0, e0);
        check("ff_error", err_cnt - e0, 1);
        check("ff_no_done", done_cnt - d0, 0);

        // 3: device never clocks
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h55);
        n = 0;
        while (!clk_oe && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (clk_oe && n < INH + 100) begin @(negedge clk); n++; end
        check("st_request_dat", {31'd0, dat_oe}, 32'd1);
        n = 0;
        while (!hif.error && n < ST + 100) begin @(negedge clk); n++; end
        check("st_timeout_cycles", n, ST);
        check("st_ready_with_error", {31'd0, hif.ready}, 32'd1);
        @(negedge clk);
        check("st_lines_released", {30'd0, clk_oe, dat_oe}, 32'd0);
        check("st_error_count", err_cnt - e0, 1);
        check("st_no_done", done_cnt - d0, 0);

        // 4: send pulsed mid-frame is ignored
        d0 = done_cnt; e0 = err_cnt; x0 = xfer_cnt;
        send_byte(8'hF4);
        dev_frame(1'b1, 1'b1, 1'b0, bits, inh);
        check("busy_bits", {21'd0, bits}, {21'd0, 1'b1, 1'b0, 8'hF4, 1'b0});
        wait_result(d0, e0);
        check("busy_done", done_cnt - d0, 1);
        repeat (200) @(negedge clk);
        check("busy_one_transfer", xfer_cnt - x0, 1);
        check("busy_idle_after", {30'd0, hif.ready, clk_oe}, 32'b10);

        // 5: reset during bit 4, then a clean frame
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hED);
        dev_frame(1'b1, 1'b0, 1'b1, bits, inh);
        check("rst_lines_drop", {30'd0, clk_oe, dat_oe}, 32'd0);
        check("rst_ready", {31'd0, hif.ready}, 32'd1);
        dev_clk = 1'b1;
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_no_pulse", {done_cnt - d0, err_cnt - e0}, 0);
        send_byte(8'hED);
        dev_frame(1'b1, 1'b0, 1'b0, bits, inh);
        check("rst_resend_bits", {21'd0, bits}, {21'd0, 1'b1, 1'b1, 8'hED, 1'b0});
        wait_result(d0, e0);
        check("rst_resend_done", done_cnt - d0, 1);

        // 6: CLK glitches while idle
        r0 = inh_hi_cnt; x0 = xfer_cnt; e0 = err_cnt;
        for (int i = 0; i < 6; i++) begin
            dev_clk = 1'b0;
            repeat (3) @(negedge clk);
            dev_clk = 1'b1;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("glitch_rx_inhibit", inh_hi_cnt - r0, 0);
        check("glitch_ready", {30'd0, hif.ready, clk_oe}, 32'b10);
        check("glitch_no_activity", {xfer_cnt - x0, err_cnt - e0}, 0);
        check("done_error_exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte from the FPGA to the keyboard, for example 0xED to set the LEDs or 0xFF to reset the keyboard.
- It is the other direction of the existing keyboard receive path (keyboard_press_driver) and shares the PS2_CLK/PS2_DAT pins with it.
- Both pins are open-drain. The top level drives them as: PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz, and likewise for DAT.

Parameters:
- INHIBIT_CYCLES, 6000: CLOCK_50 cycles to hold CLK low before the request (120 us).
- START_TIMEOUT, 750000: maximum cycles from CLK release to the first device falling edge (15 ms).
- FRAME_TIMEOUT, 100000: maximum cycles from the first falling edge to the ACK edge (2 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset_n  in  1  reset, asynchronous, active-low.
- send  in  1  request to transmit tx_data. Accepted only when ready=1.
- tx_data  in  8  command byte, captured on the accepting cycle.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse: frame sent and ACK received.
- error  out  1  one-cycle pulse: no-ACK or timeout.
- rx_inhibit  out  1  high whenever state != IDLE. The receiver ignores frames while it is high.
- ps2_clk_in  in  1  raw PS2_CLK pin, asynchronous.
- ps2_dat_in  in  1  raw PS2_DAT pin, asynchronous.
- ps2_clk_oe  out  1  1 = pull CLK low.
- ps2_dat_oe  out  1  1 = pull DAT low.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - ready=1; done=0; error=0; rx_inhibit=0; ps2_clk_oe=0; ps2_dat_oe=0.
  - All counters cleared. State = IDLE.
  - Reset asserted mid-frame releases both lines immediately.
- Input synchronisation: ps2_clk_in and ps2_dat_in each pass through 2 flops. fall = previous synced CLK 1 and current 0.
- Parity: odd, par = ~^tx_data.
- States:
  - IDLE: ready=1. On send=1, latch tx_data, clear the counter, go to INHIBIT. send=0 holds IDLE.
  - INHIBIT: clk_oe=1, dat_oe=0. After exactly INHIBIT_CYCLES cycles, set clk_oe=0 and dat_oe=1 (start bit), clear the counter, go to REQ.
  - REQ: wait for fall.
    - On the 1st fall: dat_oe=~tx_data[0], bit index=1, clear the counter, go to DATA.
    - Counter reaching START_TIMEOUT goes to ABORT.
  - DATA: each fall drives dat_oe=~tx_data[idx] and increments idx.
    - The fall with idx=8 drives dat_oe=~par and goes to PARITY.
  - PARITY: the next fall sets dat_oe=0 (stop bit, line released) and goes to ACK.
  - ACK: on the next fall, sample synced DAT.
    - DAT=0: go to WAIT_IDLE, ok flag set.
    - DAT=1: go to WAIT_IDLE, ok flag clear.
  - WAIT_IDLE: wait until synced CLK=1 and DAT=1. Then pulse done (ok) or error (not ok), and go to IDLE.
  - ABORT: release both lines, pulse error for 1 cycle, go to IDLE.
- Timeouts and edge rules:
  - The FRAME_TIMEOUT counter runs from DATA entry through ACK. Hitting the limit goes to ABORT.
  - Falls seen in IDLE or INHIBIT are ignored.
  - send while not ready is ignored. It is not queued, and the latched byte is unchanged.
- Outputs:
  - done and error are never high together.
  - done or error coincides with the cycle ready returns to 1.
  - Back-to-back send is accepted on the cycle ready is seen high.
- Widths: counters are $clog2(START_TIMEOUT+1) bits. The bit index is 4 bits.

Decomposition:
- ps2_pkg holds:
  - the state enum {IDLE, INHIBIT, REQ, DATA, PARITY, ACK, WAIT_IDLE, ABORT};
  - default timing constants;
  - an odd_parity function.
- Sub-module ps2_line_sync:
  - 2-flop synchroniser plus falling-edge detector.
  - Async active-low reset, preset to 1.
  - Instantiated once each for CLK and DAT.
  - Reusable by keyboard_press_driver.

Test Plan:
1. Basic send: send with tx_data=0xED; device model clocks at 12.5 kHz and ACKs.
   - clk_oe high for exactly 6000 cycles.
   - DAT bits sampled on device rising edges: 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - One done pulse, ready=1, no error.
2. No ACK: tx_data=0xFF; device leaves DAT high at the ACK edge.
   - Parity bit 1.
   - One error pulse after both lines are idle; done stays 0.
3. Start timeout: device never clocks after the request.
   - error pulses 750000 cycles after CLK release.
   - Both oe outputs are 0 afterwards.
4. Busy send: send pulsed with 0x00 during DATA of a 0xF4 frame.
   - Frame continues carrying 0xF4 (parity 0), one done, no second transfer.
5. Reset mid-frame: reset_n=0 during bit 4.
   - clk_oe and dat_oe drop the same cycle; ready=1; no done or error.
   - A subsequent 0xED send succeeds.
6. Glitch in IDLE: CLK toggles in IDLE.
   - No state change; rx_inhibit stays 0.
